// File: rtl/btn_pkg.sv
// Shared types, timing defaults and width helpers for the push-button
// conditioner bank.
package btn_pkg;

  // Auto-repeat state per channel; R_IDLE encodes as 0 so reset clears it.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_HOLD = 1'b1
  } rep_state_t;

  // Default timing for a 50 MHz board clock.
  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned DEF_STABLE_CYC = CLK_HZ / 1000;  // 1 ms debounce
  localparam int unsigned DEF_REPEAT_DLY = CLK_HZ / 100;   // 10 ms to first repeat
  localparam int unsigned DEF_REPEAT_PER = CLK_HZ / 500;   // 2 ms between repeats

  // Bits needed to hold any value up to max(a, b).
  function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_bank_if.sv
// Pin-side and strobe-side signal bundle of the button conditioner bank.
interface btn_debounce_bank_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] sync_o;
  logic [N_CH-1:0] btn_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] repeat_o;

  // Consumer side: drives the raw pins, observes the conditioned outputs.
  modport master (
    output btn_i,
    input  sync_o, btn_o, press_o, release_o, repeat_o
  );

  // Conditioner side.
  modport slave (
    input  btn_i,
    output sync_o, btn_o, press_o, release_o, repeat_o
  );
endinterface

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchroniser with polarity fix, stability
// counter, registered press/release strobes and optional auto-repeat.
module debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic sync_o,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);

  logic             s0;
  logic             s1;
  logic             lvl;
  logic [CNT_W-1:0] cnt;
  logic             press_q;
  logic             release_q;
  logic             accept;

  // Two-flop synchroniser; inversion happens before the first flop so s1 is pressed=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn_i ^ ACTIVE_LOW;
      s1 <= s0;
    end
  end

  // New level is accepted once it has differed for STABLE_CYC consecutive cycles.
  always_comb accept = (s1 != lvl) && (cnt == CNT_W'(STABLE_CYC - 1));

  // Stability counter; any return to the debounced level restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (s1 == lvl) begin
      cnt <= '0;
    end else if (accept) begin
      lvl <= s1;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Edge strobes registered on the same edge the debounced level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= accept & s1;
      release_q <= accept & ~s1;
    end
  end

  assign sync_o    = s1;
  assign btn_o     = lvl;
  assign press_o   = press_q;
  assign release_o = release_q;

  if (REPEAT_EN) begin : g_rep
    localparam int unsigned R_W = clog2_max(REPEAT_DLY, REPEAT_PER);

    rep_state_t     state;
    logic [R_W-1:0] rcnt;
    logic           rep_q;

    // Repeat FSM keyed off the accept edge itself, so the first repeat lands
    // exactly REPEAT_DLY cycles after the press strobe and release suppresses
    // a repeat that would otherwise coincide with it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= R_IDLE;
        rcnt  <= '0;
        rep_q <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (accept && !s1) begin
          state <= R_IDLE;
          rcnt  <= '0;
        end else begin
          case (state)
            R_IDLE: begin
              if (accept && s1) begin
                state <= R_HOLD;
                rcnt  <= R_W'(REPEAT_DLY - 1);
              end
            end
            R_HOLD: begin
              if (rcnt == '0) begin
                rep_q <= 1'b1;
                rcnt  <= R_W'(REPEAT_PER - 1);
              end else begin
                rcnt <= rcnt - R_W'(1);
              end
            end
            default: begin
              state <= R_IDLE;
              rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign repeat_o = rep_q;
  end else begin : g_norep
    assign repeat_o = 1'b0;
  end

endmodule

// File: rtl/btn_debounce_bank.sv
// Multi-channel push-button conditioner: N_CH independent debounce_ch
// instances whose outputs are concatenated onto the bank interface.
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
  input logic               clk,
  input logic               rst_n,
  btn_debounce_bank_if.slave bus
);

  logic [N_CH-1:0] sync_w;
  logic [N_CH-1:0] btn_w;
  logic [N_CH-1:0] press_w;
  logic [N_CH-1:0] release_w;
  logic [N_CH-1:0] repeat_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYC (STABLE_CYC),
      .ACTIVE_LOW (ACTIVE_LOW),
      .REPEAT_EN  (REPEAT_EN),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (bus.btn_i[i]),
      .sync_o    (sync_w[i]),
      .btn_o     (btn_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .repeat_o  (repeat_w[i])
    );
  end

  assign bus.sync_o    = sync_w;
  assign bus.btn_o     = btn_w;
  assign bus.press_o   = press_w;
  assign bus.release_o = release_w;
  assign bus.repeat_o  = repeat_w;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: directed scenarios plus random
// pin activity, every cycle compared against a window-based reference model.
module tb_btn_debounce_bank;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned STABLE = 4;
  localparam int unsigned DLY    = 8;
  localparam int unsigned PER    = 3;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] pin   = '0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  btn_debounce_bank_if #(.N_CH(N_CH)) bus ();
  assign bus.btn_i = pin;

  btn_debounce_bank #(
    .N_CH       (N_CH),
    .STABLE_CYC (STABLE),
    .ACTIVE_LOW (1'b1),
    .REPEAT_EN  (1'b1),
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  // hist[ch] bit k holds the pressed-encoded pin sample taken k+1 edges ago
  // (zeros stand for the cleared synchroniser after reset).
  logic [31:0]     hist  [N_CH];
  int unsigned     since [N_CH];
  bit              lvl   [N_CH];
  bit              hold  [N_CH];
  int unsigned     age   [N_CH];
  logic [N_CH-1:0] exp_sync, exp_btn, exp_press, exp_rel, exp_rep;

  task automatic model_reset();
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      hist[ch]  = '0;
      since[ch] = 0;
      lvl[ch]   = 1'b0;
      hold[ch]  = 1'b0;
      age[ch]   = 0;
    end
    exp_sync  = '0;
    exp_btn   = '0;
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
  endtask

  // Level flips at an edge when the synchronised samples seen at the last
  // STABLE edges all differ from the level and all of those edges lie after
  // the previous flip or reset. Repeats are derived from the age of the press.
  task automatic model_edge();
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      bit ok, pr, rl;
      since[ch]++;
      ok = (since[ch] >= STABLE);
      for (int unsigned k = 0; k < STABLE; k++)
        if (hist[ch][1 + k] == lvl[ch]) ok = 1'b0;
      pr = ok && !lvl[ch];
      rl = ok && lvl[ch];
      if (ok) begin
        lvl[ch]   = !lvl[ch];
        since[ch] = 0;
      end
      exp_rep[ch] = 1'b0;
      if (rl) begin
        hold[ch] = 1'b0;
      end else if (hold[ch]) begin
        age[ch]++;
        if (age[ch] >= DLY && ((age[ch] - DLY) % PER) == 0) exp_rep[ch] = 1'b1;
      end else if (pr) begin
        hold[ch] = 1'b1;
        age[ch]  = 0;
      end
      exp_btn[ch]   = lvl[ch];
      exp_press[ch] = pr;
      exp_rel[ch]   = rl;
      exp_sync[ch]  = hist[ch][0];
      hist[ch]      = {hist[ch][30:0], ~pin[ch]};
    end
  endtask

  task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("sync_o",    bus.sync_o,    exp_sync);
    check("btn_o",     bus.btn_o,     exp_btn);
    check("press_o",   bus.press_o,   exp_press);
    check("release_o", bus.release_o, exp_rel);
    check("repeat_o",  bus.repeat_o,  exp_rep);
    check("press_and_release", bus.press_o & bus.release_o, '0);
  endtask

  // One clock: model advances on the edge, outputs sampled 1 ns later.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned run_left [N_CH];

    // Reset with every button held: all outputs stay at 0.
    pin = 4'b0000;
    model_reset();
    #3;
    check_all();
    tick(3);
    rst_n = 1'b1;
    tick(10);

    // Release all, then ch0 bounces 1-0-1-0 with 2-cycle widths and settles pressed.
    pin = 4'b1111;
    tick(10);
    pin[0] = 1'b0; tick(2);
    pin[0] = 1'b1; tick(2);
    pin[0] = 1'b0; tick(2);
    pin[0] = 1'b1; tick(2);
    pin[0] = 1'b0; tick(10);

    // Random-width bounce on ch0 release, then settle released.
    for (int unsigned b = 0; b < 4; b++) begin
      pin[0] = ~pin[0];
      tick($urandom_range(1, STABLE - 1));
    end
    pin[0] = 1'b1;
    tick(10);

    // ch1 pressed, then a 3-cycle high glitch that must be rejected.
    pin[1] = 1'b0; tick(10);
    pin[1] = 1'b1; tick(3);
    pin[1] = 1'b0; tick(10);

    // Clean release of ch1.
    pin[1] = 1'b1; tick(10);

    // Auto-repeat on ch2 held well past the press, then release.
    pin[2] = 1'b0; tick(40);
    pin[2] = 1'b1; tick(12);

    // ch0 and ch3 pressed on the same edge, then released together.
    pin[0] = 1'b0; pin[3] = 1'b0; tick(10);
    pin[0] = 1'b1; pin[3] = 1'b1; tick(10);

    // Reset while ch2 is in the repeat phase; the held button is re-reported.
    pin[2] = 1'b0; tick(18);
    do_reset();
    tick(2);
    rst_n = 1'b1;
    tick(20);
    pin[2] = 1'b1; tick(10);

    // Random run lengths on every channel, straddling the acceptance window.
    for (int unsigned ch = 0; ch < N_CH; ch++) run_left[ch] = $urandom_range(1, 9);
    for (int unsigned c = 0; c < 600; c++) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        if (run_left[ch] == 0) begin
          pin[ch]      = ~pin[ch];
          run_left[ch] = $urandom_range(1, 9);
        end else begin
          run_left[ch]--;
        end
      end
      tick(1);
    end
    pin = 4'b1111;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_bank.md
Name: btn_debounce_bank

Overview:
- Parametrised multi-channel push-button conditioner. Successor to the single-button two-flop synchroniser.
- Per channel:
  - synchronises an asynchronous button level and applies optional polarity inversion;
  - filters bounce with a stability counter;
  - produces a clean level, single-cycle press/release strobes and optional auto-repeat strobes.
- Sits between board pins and the counter/display logic; all outputs are synchronous to clk.

Parameters:
- N_CH, 4: number of independent button channels.
- STABLE_CYC, 50000: consecutive cycles a synchronised level must differ from the debounced state before it is accepted; legal range ≥1.
- ACTIVE_LOW, 1: 1 means a pin low is a pressed button (input inverted before the synchroniser); 0 means a pin high is pressed.
- REPEAT_EN, 0: 1 enables auto-repeat strobes while a button is held.
- REPEAT_DLY, 500000: cycles from the press strobe to the first repeat strobe; legal range ≥1.
- REPEAT_PER, 100000: cycles between subsequent repeat strobes; legal range ≥1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_i  in  N_CH  raw asynchronous button pins
- sync_o  out  N_CH  second synchroniser stage (pressed=1), debug visibility
- btn_o  out  N_CH  debounced level, pressed=1
- press_o  out  N_CH  1-cycle strobe when btn_o rises
- release_o  out  N_CH  1-cycle strobe when btn_o falls
- repeat_o  out  N_CH  1-cycle auto-repeat strobe; constant 0 when REPEAT_EN=0

Behaviour:
- Reset (rst_n low, asynchronous): every flop goes to 0, so sync stages, counters, btn_o, press_o, release_o and repeat_o all read 0. No strobe is generated on reset release.
- Synchroniser per channel:
  - s0 <= btn_i ^ ACTIVE_LOW; s1 <= s0; sync_o = s1.
- Stability counter per channel:
  - Width is localparam CNT_W = clog2(STABLE_CYC+1).
  - If s1 == btn_o: cnt <= 0.
  - Else if cnt == STABLE_CYC-1: btn_o <= s1, cnt <= 0.
  - Else: cnt <= cnt+1.
  - The counter must never wrap.
- Latency: a clean raw change first sampled at edge 0 updates btn_o at edge STABLE_CYC+1. Example: STABLE_CYC=4 gives btn_o at edge 5.
- Bounce: any return of s1 to btn_o before acceptance clears cnt, so the acceptance window restarts from zero. Glitches shorter than STABLE_CYC cycles produce no btn_o change and no strobe.
- Strobes:
  - press_o is registered and asserted for exactly the cycle after btn_o goes 0→1, i.e. on the same edge btn_o updates.
  - release_o behaves the same way for 1→0.
  - press_o and release_o are never both high on one channel.
- Auto-repeat (REPEAT_EN=1), per-channel counter rcnt, width clog2(max(REPEAT_DLY,REPEAT_PER)+1):
  - Two-state FSM per channel: R_IDLE and R_HOLD.
  - R_IDLE: on press, go to R_HOLD and set rcnt <= REPEAT_DLY-1.
  - R_HOLD, rcnt == 0: pulse repeat_o and set rcnt <= REPEAT_PER-1.
  - R_HOLD, rcnt != 0: decrement rcnt.
  - Any state, btn_o low (release accepted): return to R_IDLE, rcnt <= 0, no repeat strobe in the release cycle.
  - First repeat strobe occurs REPEAT_DLY cycles after the press strobe; subsequent strobes every REPEAT_PER cycles.
- When REPEAT_EN=0, the repeat logic is not generated and repeat_o is tied to 0.
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle.
- Reset mid-operation (during a press, mid-count or in R_HOLD): all state is cleared immediately. If a button is still held after reset deasserts, it is reported as a fresh press at edge STABLE_CYC+1 after the first sampling edge.

Decomposition:
- Shared package btn_pkg:
  - repeat FSM state enum (R_IDLE, R_HOLD);
  - a width helper function (clog2 of max);
  - default timing constants for a 50 MHz board: 1 ms debounce, 10 ms / 2 ms repeat.
- Natural sub-module debounce_ch (one channel: synchroniser, stability counter, strobes, repeat FSM). The top level instantiates it N_CH times via generate and concatenates the outputs.

Test Plan (sim with STABLE_CYC=4, REPEAT_DLY=8, REPEAT_PER=3, N_CH=4, ACTIVE_LOW=1):
- Reset: hold rst_n=0 with btn_i=4'b0000 (all pressed) → all outputs 0. After release, btn_o=4'b1111 at edge 5 with press_o=4'b1111 for exactly one cycle; release_o and repeat_o stay 0.
- Bounce: ch0 pin toggles 1-0-1-0 with 2-cycle widths, then holds 0 → no change during the toggles; btn_o[0] rises exactly 5 edges after the final stable sample, with one press_o[0] pulse.
- Glitch reject: ch1 pressed and stable, pin pulses high for 3 cycles → btn_o[1] stays 1, release_o[1] never asserts.
- Release: stable pin high for ≥4 cycles after sync → btn_o drops, release_o pulses once, no press_o.
- Auto-repeat: hold ch2 for 30 cycles after press_o → repeat_o[2] pulses at +8, +11, +14, …; release stops pulses, with no repeat strobe in the release cycle.
- Independence/reset: press ch0 and ch3 on the same edge → both press strobes in the same cycle. Assert rst_n mid-R_HOLD → repeat_o stops immediately; a held button is re-reported as a press at edge 5 after reset release.
